// File: rtl/nes_prog_loader.sv
// Host-side NES command-bus loader: RESET_CPU, one WRITE_MEM per streamed byte, then START/PAUSE.
// Define NES_LOADER_CSUM_EN to add csum_o, the 8-bit wrapping sum of the bytes written this load.
module nes_prog_loader #(
  parameter int unsigned ResetCycles = 4,
  parameter int unsigned GapCycles   = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_start_i,
  input  logic [15:0] base_addr_i,
  input  logic [15:0] length_i,
  input  logic        auto_run_i,
  input  logic        cmd_run_i,
  input  logic        cmd_pause_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        write_o,
  output logic [15:0] writedata_o,
  output logic [15:0] address_o,
  output logic        busy_o,
`ifdef NES_LOADER_CSUM_EN
  output logic [7:0]  csum_o,
`endif
  output logic        done_o
);

  localparam logic [7:0] OpReset = 8'd0;
  localparam logic [7:0] OpStart = 8'd1;
  localparam logic [7:0] OpPause = 8'd2;
  localparam logic [7:0] OpWrite = 8'd3;

  typedef enum logic [2:0] {StIdle, StRst, StLoad, StGap, StFin} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic        auto_q, auto_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        rst_last, gap_last;

  assign rst_last = (cnt_q == 16'(ResetCycles - 1));
  // GAP also covers the strobe cycle itself, hence GapCycles + 1 cycles in total.
  assign gap_last = (cnt_q == 16'(GapCycles));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      auto_q  <= 1'b0;
      wd_q    <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      len_q   <= len_d;
      auto_q  <= auto_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    base_d  = base_q;
    len_d   = len_q;
    auto_d  = auto_q;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          state_d = StRst;
          cnt_d   = '0;
          idx_d   = '0;
          base_d  = base_addr_i;
          len_d   = length_i;
          auto_d  = auto_run_i;
        end
      end
      StRst: begin
        if (rst_last) begin
          cnt_d   = '0;
          state_d = (len_q == 16'd0) ? StFin : StLoad;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          state_d = StGap;
          cnt_d   = '0;
          idx_d   = idx_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_last) begin
          state_d = (idx_q == len_q) ? StFin : StLoad;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wd_d    = wd_q;
    addr_d  = addr_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          wd_d    = {OpReset, 8'h00};
          write_d = 1'b1;
        end else if (cmd_pause_i) begin
          wd_d    = {OpPause, 8'h00};
          write_d = 1'b1;
        end else if (cmd_run_i) begin
          wd_d    = {OpStart, 8'h00};
          write_d = 1'b1;
        end
      end
      StRst: begin
        if (rst_last && len_q == 16'd0) begin
          wd_d    = {auto_q ? OpStart : OpPause, 8'h00};
          write_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          wd_d    = {OpWrite, in_data_i};
          addr_d  = base_q + idx_q;
          write_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_last && idx_q == len_q) begin
          wd_d    = {auto_q ? OpStart : OpPause, 8'h00};
          write_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready_o  = (state_q == StLoad);
  assign busy_o      = (state_q != StIdle);
  assign writedata_o = wd_q;
  assign address_o   = addr_q;
  assign write_o     = write_q;
  assign done_o      = done_q;

`ifdef NES_LOADER_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else if (state_q == StIdle && load_start_i) begin
      csum_q <= '0;
    end else if (state_q == StLoad && in_valid_i) begin
      csum_q <= csum_q + in_data_i;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule
